// File: rtl/jump_commit_unit_if.sv
// jump_commit_unit_if: issue, FU result, redirect, writeback and statistics signals of the jump commit unit
// Ports (slave = jump_commit_unit, master = surrounding core):
//   issue_valid/issue_uncond/issue_rd/issue_rd_we -> unit, busy <- unit
//   fu_finish/fu_cmp_res/fu_PC_jump/fu_PC_wb -> unit
//   redirect_valid/redirect_PC/flush <- unit
//   wb_req/wb_addr/wb_data <- unit, wb_grant -> unit
//   stat_branches/stat_taken <- unit
interface jump_commit_unit_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int STAT_W = 16
);
    logic              issue_valid;
    logic              issue_uncond;
    logic [RA_W-1:0]   issue_rd;
    logic              issue_rd_we;
    logic              busy;
    logic              fu_finish;
    logic              fu_cmp_res;
    logic [XLEN-1:0]   fu_PC_jump;
    logic [XLEN-1:0]   fu_PC_wb;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_PC;
    logic              flush;
    logic              wb_req;
    logic [RA_W-1:0]   wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              wb_grant;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_taken;
    modport slave (
        input  issue_valid, issue_uncond, issue_rd, issue_rd_we,
        input  fu_finish, fu_cmp_res, fu_PC_jump, fu_PC_wb, wb_grant,
        output busy, redirect_valid, redirect_PC, flush,
        output wb_req, wb_addr, wb_data, stat_branches, stat_taken
    );
    modport master (
        output issue_valid, issue_uncond, issue_rd, issue_rd_we,
        output fu_finish, fu_cmp_res, fu_PC_jump, fu_PC_wb, wb_grant,
        input  busy, redirect_valid, redirect_PC, flush,
        input  wb_req, wb_addr, wb_data, stat_branches, stat_taken
    );
endinterface

// File: rtl/jump_commit_unit.sv
// jump_commit_unit: tracks one in-flight jump/branch, redirects fetch when taken, arbitrates link writeback
// Ports: clk, rst (synchronous, active-high), bus (jump_commit_unit_if.slave)
//   issue_* in, busy out; fu_* in; redirect_valid/redirect_PC/flush out (one-cycle pulse);
//   wb_req/wb_addr/wb_data out with wb_grant in; stat_branches/stat_taken out.
// Optional feature: define JUMP_STATS_EN for saturating resolved/taken counters (otherwise tied to 0).
module jump_commit_unit #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int STAT_W = 16
) (
    input logic clk,
    input logic rst,
    jump_commit_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_FU, RESOLVE, WB} state_t;
    state_t state, state_n;
    logic take;
    logic uncond_q, rd_we_q;
    logic [RA_W-1:0] rd_q;
    logic [XLEN-1:0] link_q;
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        take = 1'b0;
        case (state)
            IDLE:    state_n = bus.issue_valid ? WAIT_FU : IDLE;
            WAIT_FU: begin
                state_n = bus.fu_finish ? RESOLVE : WAIT_FU;
                take = bus.fu_finish && (uncond_q || bus.fu_cmp_res);
            end
            RESOLVE: state_n = (rd_we_q && rd_q != '0) ? WB : IDLE;
            WB:      state_n = bus.wb_grant ? IDLE : WB;
            default: state_n = IDLE;
        endcase
    end
    // Outputs are registered from the next-state decision so each one is valid
    // in the same cycle the FSM sits in the corresponding state.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.busy <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.flush <= 1'b0;
            bus.redirect_PC <= '0;
            bus.wb_req <= 1'b0;
            bus.wb_addr <= '0;
            bus.wb_data <= '0;
            uncond_q <= 1'b0;
            rd_we_q <= 1'b0;
            rd_q <= '0;
            link_q <= '0;
        end else begin
            bus.busy <= state_n != IDLE;
            bus.redirect_valid <= take;
            bus.flush <= take;
            bus.wb_req <= state_n == WB;
            if (state == IDLE && bus.issue_valid) begin
                uncond_q <= bus.issue_uncond;
                rd_we_q <= bus.issue_rd_we;
                rd_q <= bus.issue_rd;
            end
            if (state == WAIT_FU && bus.fu_finish) begin
                bus.redirect_PC <= bus.fu_PC_jump & ~XLEN'(1);
                link_q <= bus.fu_PC_wb;
            end
            if (state == RESOLVE && state_n == WB) begin
                bus.wb_addr <= rd_q;
                bus.wb_data <= link_q;
            end
        end
    end
`ifdef JUMP_STATS_EN
    logic [STAT_W-1:0] branches_q, taken_q;
    // redirect_valid is high in RESOLVE exactly when the jump was taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            branches_q <= '0;
            taken_q <= '0;
        end else if (state == RESOLVE) begin
            if (!(&branches_q)) branches_q <= branches_q + STAT_W'(1);
            if (bus.redirect_valid && !(&taken_q)) taken_q <= taken_q + STAT_W'(1);
        end
    end
    assign bus.stat_branches = branches_q;
    assign bus.stat_taken = taken_q;
`else
    assign bus.stat_branches = '0;
    assign bus.stat_taken = '0;
`endif
endmodule

// File: tb/tb_jump_commit_unit.sv
// tb_jump_commit_unit: directed self-checking bench for jump_commit_unit
module tb_jump_commit_unit;
`ifdef JUMP_STATS_EN
    localparam int SW = 2;
    localparam bit STATS = 1'b1;
`else
    localparam int SW = 16;
    localparam bit STATS = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    jump_commit_unit_if #(.XLEN(32), .RA_W(5), .STAT_W(SW)) bus ();
    jump_commit_unit #(.XLEN(32), .RA_W(5), .STAT_W(SW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // control bits packed as {busy, redirect_valid, flush, wb_req}
    task automatic ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, bus.busy, bus.redirect_valid, bus.flush, bus.wb_req}, {28'd0, exp});
    endtask
    task automatic issue(input logic uncond, input logic [4:0] rd, input logic we);
        bus.issue_valid = 1'b1;
        bus.issue_uncond = uncond;
        bus.issue_rd = rd;
        bus.issue_rd_we = we;
        tick();
        bus.issue_valid = 1'b0;
    endtask
    task automatic finish(input logic cmp, input logic [31:0] jump, input logic [31:0] link);
        bus.fu_finish = 1'b1;
        bus.fu_cmp_res = cmp;
        bus.fu_PC_jump = jump;
        bus.fu_PC_wb = link;
        tick();
        bus.fu_finish = 1'b0;
    endtask
    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_uncond = 1'b0;
        bus.issue_rd = '0;
        bus.issue_rd_we = 1'b0;
        bus.fu_finish = 1'b0;
        bus.fu_cmp_res = 1'b0;
        bus.fu_PC_jump = '0;
        bus.fu_PC_wb = '0;
        bus.wb_grant = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        ctl("reset_ctl", 4'b0000);
        chk("reset_rpc", bus.redirect_PC, 32'h0);
        chk("reset_wb_addr", {27'd0, bus.wb_addr}, 32'h0);
        chk("reset_wb_data", bus.wb_data, 32'h0);
        chk("reset_stat_br", 32'(bus.stat_branches), 32'h0);
        chk("reset_stat_tk", 32'(bus.stat_taken), 32'h0);
        // JAL rd=1: redirect to 0x200, then write back 0x104
        issue(1'b1, 5'd1, 1'b1);
        ctl("jal_wait", 4'b1000);
        finish(1'b0, 32'h200, 32'h104);
        ctl("jal_resolve", 4'b1110);
        chk("jal_rpc", bus.redirect_PC, 32'h200);
        tick();
        ctl("jal_wb", 4'b1001);
        chk("jal_wb_addr", {27'd0, bus.wb_addr}, 32'd1);
        chk("jal_wb_data", bus.wb_data, 32'h104);
        bus.wb_grant = 1'b1;
        tick();
        bus.wb_grant = 1'b0;
        ctl("jal_done", 4'b0000);
        // not-taken BEQ without rd write
        issue(1'b0, 5'd3, 1'b0);
        ctl("beq_wait", 4'b1000);
        finish(1'b0, 32'h400, 32'h204);
        ctl("beq_resolve", 4'b1000);
        tick();
        ctl("beq_idle", 4'b0000);
        // JALR rd=0, issued in the first idle cycle, odd target
        issue(1'b1, 5'd0, 1'b1);
        ctl("jalr_wait", 4'b1000);
        finish(1'b0, 32'h301, 32'h208);
        ctl("jalr_resolve", 4'b1110);
        chk("jalr_rpc", bus.redirect_PC, 32'h300);
        tick();
        ctl("jalr_no_wb", 4'b0000);
        // taken branch rd=7 with a stalled grant and ignored issues
        issue(1'b0, 5'd7, 1'b1);
        finish(1'b1, 32'h500, 32'h48);
        ctl("br_resolve", 4'b1110);
        chk("br_rpc", bus.redirect_PC, 32'h500);
        bus.issue_valid = 1'b1;
        bus.issue_rd = 5'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            ctl("stall_ctl", 4'b1001);
            chk("stall_addr", {27'd0, bus.wb_addr}, 32'd7);
            chk("stall_data", bus.wb_data, 32'h48);
        end
        bus.issue_valid = 1'b0;
        bus.wb_grant = 1'b1;
        tick();
        bus.wb_grant = 1'b0;
        ctl("stall_done", 4'b0000);
        issue(1'b1, 5'd2, 1'b1);
        ctl("after_stall_issue", 4'b1000);
        // reset in WAIT_FU, then late finish/grant
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ctl("rst_wait_ctl", 4'b0000);
        chk("rst_wait_rpc", bus.redirect_PC, 32'h0);
        chk("rst_wait_wb_addr", {27'd0, bus.wb_addr}, 32'h0);
        chk("rst_wait_wb_data", bus.wb_data, 32'h0);
        finish(1'b1, 32'h600, 32'h64);
        ctl("late_finish", 4'b0000);
        chk("late_finish_rpc", bus.redirect_PC, 32'h0);
        bus.wb_grant = 1'b1;
        tick();
        bus.wb_grant = 1'b0;
        ctl("late_grant", 4'b0000);
        // reset in WB
        issue(1'b1, 5'd4, 1'b1);
        finish(1'b0, 32'h700, 32'h74);
        tick();
        ctl("pre_rst_wb", 4'b1001);
        chk("pre_rst_wb_addr", {27'd0, bus.wb_addr}, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ctl("rst_wb_ctl", 4'b0000);
        chk("rst_wb_addr", {27'd0, bus.wb_addr}, 32'h0);
        chk("rst_wb_data", bus.wb_data, 32'h0);
        chk("rst_stat_br", 32'(bus.stat_branches), 32'h0);
        chk("rst_stat_tk", 32'(bus.stat_taken), 32'h0);
        bus.wb_grant = 1'b1;
        tick();
        bus.wb_grant = 1'b0;
        ctl("rst_late_grant", 4'b0000);
        // statistics: one not-taken branch, then taken jumps until saturation
        issue(1'b0, 5'd0, 1'b0);
        finish(1'b0, 32'h800, 32'h84);
        tick();
        issue(1'b1, 5'd0, 1'b0);
        finish(1'b0, 32'h900, 32'h94);
        tick();
        chk("stat_br_mid", 32'(bus.stat_branches), STATS ? 32'd2 : 32'd0);
        chk("stat_tk_mid", 32'(bus.stat_taken), STATS ? 32'd1 : 32'd0);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 5'd0, 1'b0);
            finish(1'b0, 32'hA00, 32'hA4);
            ctl("stat_resolve", 4'b1110);
            tick();
        end
        chk("stat_br_sat", 32'(bus.stat_branches), STATS ? 32'd3 : 32'd0);
        chk("stat_tk_sat", 32'(bus.stat_taken), STATS ? 32'd3 : 32'd0);
        ctl("final_idle", 4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
